// File: rtl/frame_reader.sv
// Streams the 28x28 RGB565 frame buffer out as 8-bit grayscale pixels over valid/ready.
// Optional build macro FRAME_READER_BINARIZE_EN thresholds each pixel at THRESH to 0x00/0xFF.
module frame_reader #(
    parameter int OUT_W  = 28,
    parameter int OUT_H  = 28,
    parameter int RD_LAT = 1,
    parameter int THRESH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  bram_addr_rd,
    output logic        bram_en_rd,
    output logic        bram_we_rd,
    input  logic [15:0] bram_dout,
    output logic [7:0]  pix_data,
    output logic [9:0]  pix_index,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    localparam int          NPIX      = OUT_W * OUT_H;
    localparam logic [9:0]  LAST_IDX  = 10'(NPIX - 1);
    localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);

    // Parameter sanity: the address bus is 10 bits and the wait counter only handles latency 1 or 2.
    if (NPIX < 1 || NPIX > 1024) begin : g_badSize
        $error("frame_reader: OUT_W*OUT_H must be 1..1024");
    end
    if (RD_LAT < 1 || RD_LAT > 2) begin : g_badLat
        $error("frame_reader: RD_LAT must be 1 or 2");
    end
    if (THRESH < 0 || THRESH > 255) begin : g_badThresh
        $error("frame_reader: THRESH must be 0..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [9:0]  r_count;
    logic [1:0]  r_waitCnt;
    logic        r_en;
    logic [7:0]  r_pixData;
    logic        r_valid;
    logic        r_last;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] w_sum;
    logic [7:0]  w_gray;
    logic [7:0]  w_pix;

    // Replicate the top bits to widen RGB565 channels to 8 bits; weights sum to 256 so the 16-bit sum never overflows.
    assign w_r8   = {bram_dout[15:11], bram_dout[15:13]};
    assign w_g8   = {bram_dout[10:5],  bram_dout[10:9]};
    assign w_b8   = {bram_dout[4:0],   bram_dout[4:2]};
    assign w_sum  = 16'd77 * {8'd0, w_r8} + 16'd150 * {8'd0, w_g8} + 16'd29 * {8'd0, w_b8};
    assign w_gray = w_sum[15:8];

`ifdef FRAME_READER_BINARIZE_EN
    assign w_pix = (w_gray >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
    assign w_pix = w_gray;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_waitCnt <= '0;
            r_en      <= 1'b0;
            r_pixData <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_en    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_waitCnt <= '0;
                    r_state   <= S_WAIT;
                end
                // Capture converted read data on the cycle it becomes valid at the BRAM output.
                S_WAIT: begin
                    if (r_waitCnt == WAIT_LAST) begin
                        r_pixData <= w_pix;
                        r_valid   <= 1'b1;
                        r_last    <= (r_count == LAST_IDX);
                        r_state   <= S_PRESENT;
                    end else begin
                        r_waitCnt <= r_waitCnt + 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (pix_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_count == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_count <= r_count + 10'd1;
                            r_en    <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bram_addr_rd = r_count;
    assign bram_en_rd   = r_en;
    assign bram_we_rd   = 1'b0;
    assign pix_data     = r_pixData;
    assign pix_index    = r_count;
    assign pix_valid    = r_valid;
    assign pix_last     = r_last;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: doc/frame_reader.md
# frame_reader

Reads the 28x28 averaged-pixel frame buffer after capture completes and streams it out as 784 8-bit grayscale pixels in raster order over a valid/ready handshake. Sits on the system-clock side of the frame BRAM, opposite the camera capture writer, and feeds the digit-recognition datapath. Converts each stored 16-bit RGB565 word to luminance and optionally binarizes it.

## Interface
- OUT_W, 28: frame width in pixels.
- OUT_H, 28: frame height in pixels.
- RD_LAT, 1: BRAM read latency in cycles (1 or 2).
- THRESH, 128: binarization threshold (used only with the configuration macro).

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to read one frame (driven from frame_done).
- bram_addr_rd  output  10  read address, 0..783.
- bram_en_rd  output  1  read enable.
- bram_we_rd  output  1  constant 0.
- bram_dout  input  16  RGB565 read data, valid RD_LAT cycles after bram_en_rd.
- pix_data  output  8  grayscale pixel.
- pix_index  output  10  raster index of pix_data (y*OUT_W + x).
- pix_valid  output  1  pix_data/pix_index/pix_last valid.
- pix_ready  input  1  consumer accepts when high with pix_valid.
- pix_last  output  1  high with pixel 783.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after last pixel accepted.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE: start=1 -> addr counter := 0, busy := 1, go ISSUE. start while busy is ignored (not queued).
- ISSUE: one cycle, bram_en_rd=1, bram_addr_rd=counter; go WAIT.
- WAIT: count RD_LAT cycles; on final cycle register bram_dout through gray conversion into pix_data; go PRESENT.
- PRESENT: pix_valid=1; outputs held stable until pix_valid&&pix_ready. On handshake: if counter==OUT_W*OUT_H-1 go DONE, else counter+1, go ISSUE.
- DONE: done=1 for one cycle, busy := 0, go IDLE.
- Gray: r8={R5,R5[4:2]}, g8={G6,G6[5:4]}, b8={B5,B5[4:2]} from d[15:11], d[10:5], d[4:0]; gray=(77*r8+150*g8+29*b8)>>8, 16-bit unsigned intermediate (max 65280, no overflow).
- pix_last = pix_valid && counter==783. pix_index = counter.

## Timing
- Reset values: bram_addr_rd=0, bram_en_rd=0, bram_we_rd=0, pix_data=0, pix_index=0, pix_valid=0, pix_last=0, busy=0, done=0; state IDLE.
- start sampled at edge N -> bram_en_rd high cycle N+1 -> pix_valid high from cycle N+2+RD_LAT.
- With pix_ready held high: one pixel per RD_LAT+2 cycles; full frame 784*(RD_LAT+2) cycles plus 1 for DONE.
- bram_en_rd is high exactly one cycle per pixel; never high outside ISSUE.
- pix_ready low holds PRESENT indefinitely; no data loss, no extra reads.
- reset mid-frame: next cycle all outputs at reset values, state IDLE; partial frame abandoned.
- start coincident with reset: reset wins.
- start in DONE cycle: ignored.

## Configuration
- FRAME_READER_BINARIZE_EN defined: pix_data = (gray >= THRESH) ? 8'hFF : 8'h00.
- Undefined: pix_data = gray. Timing identical in both builds.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, bram_en_rd never asserted.
- BRAM preloaded word k = k, RD_LAT=1, start, pix_ready=1 -> 784 pixels, indices 0..783 in order, first pix_valid at start+3, pix_last only on index 783, done pulse one cycle later, busy low after.
- Words 0xFFFF, 0x0000, 0xF800, 0x07E0, 0x001F -> pix_data 255, 0, 76, 149, 28.
- pix_ready toggled pseudo-randomly -> same sequence, pix_data stable while valid&&!ready, exactly 784 bram_en_rd pulses.
- Reset asserted at pixel 300 then start -> stream restarts at index 0, completes 784 pixels; start pulsed mid-frame -> ignored.
- FRAME_READER_BINARIZE_EN, THRESH=128, words 0xFFFF/0xF800/0x07E0 -> 0xFF/0x00/0xFF.
